// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared constants, clear FSM states and byte merge for ram_dp_be
package ram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_t;

    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       be
    );
        return be ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// rtl/ram_rd_pipe.sv - per-port read pipeline: latency stage, valid strobe, hold register, oe gating
module ram_rd_pipe
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rd,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_oe,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic                  o_valid
);

    logic                  w_fill;
    logic [DATA_WIDTH-1:0] w_fill_data;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_hold;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  r_s1_vld;
            logic [DATA_WIDTH-1:0] r_s1_data;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1_vld  <= 1'b0;
                    r_s1_data <= '0;
                end else begin
                    r_s1_vld <= i_rd;
                    if (i_rd) begin
                        r_s1_data <= i_data;
                    end
                end
            end

            assign w_fill      = r_s1_vld;
            assign w_fill_data = r_s1_data;
        end else begin : g_lat1
            assign w_fill      = i_rd;
            assign w_fill_data = i_data;
        end
    endgenerate

    // Hold register keeps the last completed read until the next one lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_valid <= w_fill;
            if (w_fill) begin
                r_hold <= w_fill_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_dout  = i_oe ? r_hold : '0;

endmodule

// File: rtl/ram_dp_be.sv
// rtl/ram_dp_be.sv - true dual-port byte-enable RAM; optional clear sweep under RAM_INIT_CLEAR_EN
module ram_dp_be
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_cs,
    input  logic                    a_we,
    input  logic                    a_oe,
    input  logic [DATA_WIDTH/8-1:0] a_be,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_din,
    output logic [DATA_WIDTH-1:0]   a_dout,
    output logic                    a_valid,
    input  logic                    b_cs,
    input  logic                    b_we,
    input  logic                    b_oe,
    input  logic [DATA_WIDTH/8-1:0] b_be,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic [DATA_WIDTH-1:0]   b_din,
    output logic [DATA_WIDTH-1:0]   b_dout,
    output logic                    b_valid,
    output logic                    busy,
    output logic                    collision
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    logic                  w_busy;
    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_addr;

`ifdef RAM_INIT_CLEAR_EN
    clr_state_t            r_state;
    clr_state_t            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic [ADDR_WIDTH-1:0] w_clr_addr_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        case (r_state)
            CLEAR: begin
                w_clr_addr_nxt = r_clr_addr + ADDR_WIDTH'(1);
                if (r_clr_addr == {ADDR_WIDTH{1'b1}}) begin
                    w_state_nxt = READY;
                end
            end
            default: begin
            end
        endcase
    end

    assign w_busy     = (r_state == CLEAR);
    assign w_clr_we   = w_busy;
    assign w_clr_addr = r_clr_addr;
`else
    assign w_busy     = 1'b0;
    assign w_clr_we   = 1'b0;
    assign w_clr_addr = '0;
`endif

    logic                  w_a_wr, w_b_wr, w_a_rd, w_b_rd, w_same;
    logic [DATA_WIDTH-1:0] w_a_old, w_b_old, w_a_base, w_a_new, w_b_new;
    logic [DATA_WIDTH-1:0] w_a_rd_data, w_b_rd_data;

    assign w_a_wr = a_cs & a_we & ~w_busy;
    assign w_b_wr = b_cs & b_we & ~w_busy;
    assign w_a_rd = a_cs & ~a_we & ~w_busy;
    assign w_b_rd = b_cs & ~b_we & ~w_busy;
    assign w_same = (a_addr == b_addr);

    assign w_a_old = r_mem[a_addr];
    assign w_b_old = r_mem[b_addr];

    always_comb begin
        w_b_new = w_b_old;
        for (int i = 0; i < NB; i++) begin
            w_b_new[i*8 +: 8] = byte_merge(w_b_old[i*8 +: 8], b_din[i*8 +: 8], b_be[i]);
        end
    end

    // On a same-address double write, A is merged on top of B's result so A wins shared bytes.
    assign w_a_base = (w_b_wr && w_same) ? w_b_new : w_a_old;

    always_comb begin
        w_a_new = w_a_base;
        for (int i = 0; i < NB; i++) begin
            w_a_new[i*8 +: 8] = byte_merge(w_a_base[i*8 +: 8], a_din[i*8 +: 8], a_be[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else begin
            if (w_b_wr && !(w_a_wr && w_same)) begin
                r_mem[b_addr] <= w_b_new;
            end
            if (w_a_wr) begin
                r_mem[a_addr] <= w_a_new;
            end
        end
    end

    assign w_a_rd_data = (RDW_MODE == RDW_WRITE_FIRST && w_b_wr && w_same) ? w_b_new : w_a_old;
    assign w_b_rd_data = (RDW_MODE == RDW_WRITE_FIRST && w_a_wr && w_same) ? w_a_new : w_b_old;

    logic r_collision;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_collision <= 1'b0;
        end else begin
            r_collision <= w_a_wr & w_b_wr & w_same;
        end
    end

    assign collision = r_collision;
    assign busy      = w_busy;

    ram_rd_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_pipe_a (
        .clk    (clk),
        .rst    (rst),
        .i_rd   (w_a_rd),
        .i_data (w_a_rd_data),
        .i_oe   (a_oe),
        .o_dout (a_dout),
        .o_valid(a_valid)
    );

    ram_rd_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_pipe_b (
        .clk    (clk),
        .rst    (rst),
        .i_rd   (w_b_rd),
        .i_data (w_b_rd_data),
        .i_oe   (b_oe),
        .o_dout (b_dout),
        .o_valid(b_valid)
    );

endmodule

// File: tb/tb_ram_dp_be.sv
// tb/tb_ram_dp_be.sv - directed bench for ram_dp_be (latency 1/read-first and latency 2/write-first)
module tb_ram_dp_be;

    logic        clk;
    logic        rst;
    logic        a_cs, a_we, a_oe, b_cs, b_we, b_oe;
    logic [1:0]  a_be, b_be;
    logic [7:0]  a_addr, b_addr;
    logic [15:0] a_din, b_din;

    logic [15:0] l1_a_dout, l1_b_dout, l2_a_dout, l2_b_dout;
    logic        l1_a_valid, l1_b_valid, l2_a_valid, l2_b_valid;
    logic        l1_busy, l2_busy, l1_collision, l2_collision;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_busy_cycles;
    logic exp_busy_rst;

    ram_dp_be #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .READ_LATENCY(1), .RDW_MODE(0)) dut_l1 (
        .clk(clk), .rst(rst),
        .a_cs(a_cs), .a_we(a_we), .a_oe(a_oe), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
        .a_dout(l1_a_dout), .a_valid(l1_a_valid),
        .b_cs(b_cs), .b_we(b_we), .b_oe(b_oe), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
        .b_dout(l1_b_dout), .b_valid(l1_b_valid),
        .busy(l1_busy), .collision(l1_collision)
    );

    ram_dp_be #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .READ_LATENCY(2), .RDW_MODE(1)) dut_l2 (
        .clk(clk), .rst(rst),
        .a_cs(a_cs), .a_we(a_we), .a_oe(a_oe), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
        .a_dout(l2_a_dout), .a_valid(l2_a_valid),
        .b_cs(b_cs), .b_we(b_we), .b_oe(b_oe), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
        .b_dout(l2_b_dout), .b_valid(l2_b_valid),
        .busy(l2_busy), .collision(l2_collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_cs = 1'b0; a_we = 1'b0; a_be = 2'b00; a_addr = 8'h00; a_din = 16'h0000;
        b_cs = 1'b0; b_we = 1'b0; b_be = 2'b00; b_addr = 8'h00; b_din = 16'h0000;
    endtask

    task automatic drive_a(input logic we, input logic [7:0] addr, input logic [15:0] din, input logic [1:0] be);
        a_cs = 1'b1; a_we = we; a_addr = addr; a_din = din; a_be = be;
    endtask

    task automatic drive_b(input logic we, input logic [7:0] addr, input logic [15:0] din, input logic [1:0] be);
        b_cs = 1'b1; b_we = we; b_addr = addr; b_din = din; b_be = be;
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while ((l1_busy || l2_busy) && cycles < 1000) begin
            step();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        a_oe = 1'b1; b_oe = 1'b1;
        step(); step();
        n_checks++; if (l1_a_valid !== 1'b0) $display("FAIL reset_l1_a_valid: got %b expected 0", l1_a_valid); else n_pass++;
        n_checks++; if (l2_b_valid !== 1'b0) $display("FAIL reset_l2_b_valid: got %b expected 0", l2_b_valid); else n_pass++;
        n_checks++; if (l1_a_dout !== 16'h0000) $display("FAIL reset_l1_a_dout: got %h expected 0000", l1_a_dout); else n_pass++;
        n_checks++; if (l2_b_dout !== 16'h0000) $display("FAIL reset_l2_b_dout: got %h expected 0000", l2_b_dout); else n_pass++;
        n_checks++; if (l1_collision !== 1'b0) $display("FAIL reset_collision: got %b expected 0", l1_collision); else n_pass++;
        n_checks++; if (l1_busy !== exp_busy_rst) $display("FAIL reset_busy: got %b expected %b", l1_busy, exp_busy_rst); else n_pass++;
    endtask

    task automatic test_clear_sweep();
        int cycles;
        rst = 1'b0;
        wait_ready(cycles);
        n_checks++; if (cycles !== exp_busy_cycles) $display("FAIL sweep_len: got %0d expected %0d", cycles, exp_busy_cycles); else n_pass++;
`ifdef RAM_INIT_CLEAR_EN
        drive_a(1'b0, 8'h07, 16'h0000, 2'b00);
        step();
        idle();
        n_checks++; if (l1_a_dout !== 16'h0000) $display("FAIL sweep_read7: got %h expected 0000", l1_a_dout); else n_pass++;
`endif
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 9; i++) step();
        rst = 1'b1; step(); rst = 1'b0;
        wait_ready(cycles);
        n_checks++; if (cycles !== exp_busy_cycles) $display("FAIL sweep_restart_len: got %0d expected %0d", cycles, exp_busy_cycles); else n_pass++;
    endtask

    task automatic test_byte_enable();
        drive_a(1'b1, 8'h10, 16'hBEEF, 2'b11); step();
        drive_a(1'b1, 8'h10, 16'h1200, 2'b10); step();
        drive_a(1'b0, 8'h10, 16'hFFFF, 2'b11); step();
        idle();
        n_checks++; if (l1_a_valid !== 1'b1) $display("FAIL be_l1_valid: got %b expected 1", l1_a_valid); else n_pass++;
        n_checks++; if (l1_a_dout !== 16'h12EF) $display("FAIL be_l1_dout: got %h expected 12ef", l1_a_dout); else n_pass++;
        n_checks++; if (l2_a_valid !== 1'b0) $display("FAIL be_l2_early_valid: got %b expected 0", l2_a_valid); else n_pass++;
        step();
        n_checks++; if (l1_a_valid !== 1'b0) $display("FAIL be_l1_valid_drop: got %b expected 0", l1_a_valid); else n_pass++;
        n_checks++; if (l2_a_valid !== 1'b1) $display("FAIL be_l2_valid: got %b expected 1", l2_a_valid); else n_pass++;
        n_checks++; if (l2_a_dout !== 16'h12EF) $display("FAIL be_l2_dout: got %h expected 12ef", l2_a_dout); else n_pass++;
        step();
        n_checks++; if (l2_a_valid !== 1'b0) $display("FAIL be_l2_valid_drop: got %b expected 0", l2_a_valid); else n_pass++;
    endtask

    task automatic test_rdw();
        drive_a(1'b1, 8'h22, 16'h0055, 2'b11); step();
        drive_a(1'b1, 8'h22, 16'h00AA, 2'b11);
        drive_b(1'b0, 8'h22, 16'h0000, 2'b00);
        step();
        idle();
        n_checks++; if (l1_b_dout !== 16'h0055) $display("FAIL rdw_first_b: got %h expected 0055", l1_b_dout); else n_pass++;
        step();
        n_checks++; if (l2_b_dout !== 16'h00AA) $display("FAIL rdw_write_first_b: got %h expected 00aa", l2_b_dout); else n_pass++;
        drive_b(1'b1, 8'h22, 16'h0033, 2'b11);
        drive_a(1'b0, 8'h22, 16'h0000, 2'b00);
        step();
        idle();
        n_checks++; if (l1_a_dout !== 16'h00AA) $display("FAIL rdw_first_a: got %h expected 00aa", l1_a_dout); else n_pass++;
        step();
        n_checks++; if (l2_a_dout !== 16'h0033) $display("FAIL rdw_write_first_a: got %h expected 0033", l2_a_dout); else n_pass++;
    endtask

    task automatic test_collision();
        drive_a(1'b1, 8'h05, 16'h0011, 2'b11);
        drive_b(1'b1, 8'h05, 16'h0022, 2'b11);
        step();
        idle();
        n_checks++; if (l1_collision !== 1'b1) $display("FAIL coll_l1_pulse: got %b expected 1", l1_collision); else n_pass++;
        n_checks++; if (l2_collision !== 1'b1) $display("FAIL coll_l2_pulse: got %b expected 1", l2_collision); else n_pass++;
        drive_a(1'b0, 8'h05, 16'h0000, 2'b00);
        step();
        idle();
        n_checks++; if (l1_collision !== 1'b0) $display("FAIL coll_drop: got %b expected 0", l1_collision); else n_pass++;
        n_checks++; if (l1_a_dout !== 16'h0011) $display("FAIL coll_a_wins: got %h expected 0011", l1_a_dout); else n_pass++;
        drive_a(1'b1, 8'h06, 16'h0011, 2'b01);
        drive_b(1'b1, 8'h06, 16'h2222, 2'b11);
        step();
        drive_a(1'b0, 8'h06, 16'h0000, 2'b00);
        b_cs = 1'b0;
        step();
        idle();
        n_checks++; if (l1_a_dout !== 16'h2211) $display("FAIL coll_byte_mix: got %h expected 2211", l1_a_dout); else n_pass++;
        step();
    endtask

    task automatic test_output_control();
        drive_a(1'b1, 8'h30, 16'h00AA, 2'b11); step();
        a_oe = 1'b0;
        drive_a(1'b0, 8'h30, 16'h0000, 2'b00); step();
        idle();
        n_checks++; if (l1_a_valid !== 1'b1 || l1_a_dout !== 16'h0000) $display("FAIL oe_low_l1: got valid %b dout %h expected 1 0000", l1_a_valid, l1_a_dout); else n_pass++;
        step();
        n_checks++; if (l2_a_valid !== 1'b1 || l2_a_dout !== 16'h0000) $display("FAIL oe_low_l2: got valid %b dout %h expected 1 0000", l2_a_valid, l2_a_dout); else n_pass++;
        a_oe = 1'b1;
        #1;
        n_checks++; if (l1_a_dout !== 16'h00AA) $display("FAIL oe_high_l1: got %h expected 00aa", l1_a_dout); else n_pass++;
        n_checks++; if (l2_a_dout !== 16'h00AA) $display("FAIL oe_high_l2: got %h expected 00aa", l2_a_dout); else n_pass++;
        drive_a(1'b1, 8'h31, 16'h1234, 2'b11); step();
        idle();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (l1_a_valid !== 1'b0 || l2_a_valid !== 1'b0)
                $display("FAIL write_no_valid[%0d]: got l1 %b l2 %b expected 0 0", i, l1_a_valid, l2_a_valid);
            else n_pass++;
            step();
        end
        n_checks++; if (l2_a_dout !== 16'h00AA) $display("FAIL hold_after_write: got %h expected 00aa", l2_a_dout); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_word [4];
        for (int i = 0; i < 4; i++) begin
            exp_word[i] = 16'h1000 + 16'(i) * 16'h0101;
            drive_a(1'b1, 8'h40 + 8'(i), exp_word[i], 2'b11);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b0, 8'h40 + 8'(i), 16'h0000, 2'b00);
            step();
            n_checks++;
            if (l1_a_valid !== 1'b1 || l1_a_dout !== exp_word[i])
                $display("FAIL b2b_l1[%0d]: got valid %b dout %h expected 1 %h", i, l1_a_valid, l1_a_dout, exp_word[i]);
            else n_pass++;
            if (i > 0) begin
                n_checks++;
                if (l2_a_valid !== 1'b1 || l2_a_dout !== exp_word[i-1])
                    $display("FAIL b2b_l2[%0d]: got valid %b dout %h expected 1 %h", i, l2_a_valid, l2_a_dout, exp_word[i-1]);
                else n_pass++;
            end
        end
        idle();
        step();
        n_checks++;
        if (l2_a_valid !== 1'b1 || l2_a_dout !== exp_word[3] || l1_a_valid !== 1'b0)
            $display("FAIL b2b_tail: got l2 valid %b dout %h l1 valid %b expected 1 %h 0", l2_a_valid, l2_a_dout, l1_a_valid, exp_word[3]);
        else n_pass++;
        step();
    endtask

    task automatic test_reset_inflight();
        int cycles;
        drive_a(1'b0, 8'h40, 16'h0000, 2'b00);
        step();
        idle();
        n_checks++; if (l1_a_valid !== 1'b1) $display("FAIL inflight_l1_pre: got %b expected 1", l1_a_valid); else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (l2_a_valid !== 1'b0) $display("FAIL inflight_l2_flush: got %b expected 0", l2_a_valid); else n_pass++;
        n_checks++; if (l2_a_dout !== 16'h0000) $display("FAIL inflight_l2_dout: got %h expected 0000", l2_a_dout); else n_pass++;
        step();
        n_checks++; if (l2_a_valid !== 1'b0) $display("FAIL inflight_l2_late: got %b expected 0", l2_a_valid); else n_pass++;
        wait_ready(cycles);
        n_checks++; if (cycles !== (exp_busy_cycles > 0 ? exp_busy_cycles - 1 : 0)) $display("FAIL inflight_ready: got %0d expected %0d", cycles, (exp_busy_cycles > 0 ? exp_busy_cycles - 1 : 0)); else n_pass++;
    endtask

    initial begin
`ifdef RAM_INIT_CLEAR_EN
        exp_busy_cycles = 256;
        exp_busy_rst    = 1'b1;
`else
        exp_busy_cycles = 0;
        exp_busy_rst    = 1'b0;
`endif
        rst = 1'b1;
        a_oe = 1'b1; b_oe = 1'b1;
        idle();
        test_reset();
        test_clear_sweep();
        test_byte_enable();
        test_rdw();
        test_collision();
        test_output_control();
        test_back_to_back();
        test_reset_inflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_dp_be.md
# ram_dp_be

Parametrised true dual-port synchronous RAM with per-byte write enables, a selectable read latency of 1 or 2 cycles, and defined same-address collision behaviour. It replaces the single-port tristate RAM in the storage layer. Each port has separate data-in and data-out buses and a read-valid strobe. An optional post-reset clear sweep zeroes the array.

## Interface
Parameters:
- DATA_WIDTH, 8: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8: address width; depth is 2**ADDR_WIDTH words.
- READ_LATENCY, 1: read latency in cycles; legal values are 1 or 2.
- RDW_MODE, 0: cross-port read-during-write; 0 returns old data (read-first), 1 returns new merged data (write-first).

Ports (x = a or b; both ports are identical):
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- x_cs  in  1  port select.
- x_we  in  1  1 = write, 0 = read.
- x_oe  in  1  output enable for x_dout.
- x_be  in  DATA_WIDTH/8  byte enables for writes.
- x_addr  in  ADDR_WIDTH  word address.
- x_din  in  DATA_WIDTH  write data.
- x_dout  out  DATA_WIDTH  read data.
- x_valid  out  1  one-cycle strobe marking new read data.
- busy  out  1  high while the clear sweep runs; requests are ignored.
- collision  out  1  one-cycle pulse when both ports write the same address.

## Operation
- Access accepted: x_cs=1 and busy=0, sampled at the rising edge.
- Write (x_we=1): bytes i with x_be[i]=1 are updated; other bytes keep their value. A write produces no x_valid.
- Read (x_we=0): data for x_addr enters the port output pipeline. x_be and x_din are ignored.
- Read data register holds the last completed read until the next read completes.
- x_dout is combinational: 0 while x_oe=0, otherwise the read data register. x_oe does not affect x_valid or the pipeline.
- Same-port write to an address, then read of it in the next cycle: the read returns the written data.
- Cross-port, port A writes and port B reads the same address in the same cycle:
  - RDW_MODE=0: B returns the pre-write word.
  - RDW_MODE=1: B returns the word with A's enabled bytes merged in.
  - The rule is symmetric when B writes and A reads.
- Both ports write the same address in the same cycle:
  - Port A wins on bytes enabled by both ports.
  - Bytes enabled by B only take B's data.
  - collision is high in the following cycle.
- Both ports reading the same address is legal and has no side effects.

## Timing
- Request sampled at edge k: x_dout data is updated and x_valid is high during cycle k+READ_LATENCY, for exactly one cycle.
- Reads are fully pipelined. Back-to-back reads give one valid per cycle.
- Reset values: x_valid=0, read data registers=0 (x_dout=0), collision=0, busy=1 with RAM_INIT_CLEAR_EN else 0.
- Reset flushes the read pipeline. In-flight reads never produce x_valid.
- Clear FSM states:
  - CLEAR: entered from reset. Writes 0 to the address held by an ADDR_WIDTH counter, which increments each cycle.
  - At the last address (counter = 2**ADDR_WIDTH-1), the FSM moves to READY after that write.
  - busy falls on the edge that enters READY. The sweep takes exactly 2**ADDR_WIDTH cycles after rst deasserts.
  - rst asserted during CLEAR restarts the sweep from address 0.
- While busy=1, requests are dropped: no write, no x_valid, no collision.
- Address counters and addresses wrap naturally. No out-of-range accesses exist.

## Configuration
- RAM_INIT_CLEAR_EN defined: the clear FSM and counter are present, and busy behaves as above.
- RAM_INIT_CLEAR_EN undefined: busy is tied to 0 and the first access may occur in the cycle after rst deasserts.
  - rst affects only the pipeline and output registers.
  - Memory contents are undefined after power-up and unchanged by rst.

## Structure
- Package ram_pkg holds:
  - RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1 constants.
  - The clear FSM state enum (CLEAR, READY).
  - A byte-merge function (old, new, be).
- Sub-module ram_rd_pipe: per-port output pipeline (latency stage, valid shift, hold register, oe gating), instantiated once per port.
- The top level holds the array, write/collision arbitration and the clear FSM.

## Test plan
- Clear sweep (macro on, ADDR_WIDTH=4): busy is high for 16 cycles after rst falls. A read of 0x7 then returns 0x00.
- Byte-enable write: DATA_WIDTH=16; write 0xBEEF to 0x10 with be=11, then 0x1200 with be=10 → read returns 0x12EF with a_valid at latency 1 and at latency 2.
- Cross-port read-during-write:
  - Setup: 0x22 holds 0x55; A writes 0xAA to 0x22 while B reads 0x22.
  - Expected: B gets 0x55 with RDW_MODE=0 and 0xAA with RDW_MODE=1.
- Write collision: A writes 0x11 and B writes 0x22 to 0x05 in the same cycle → collision pulses once; a later read returns 0x11.
- Output control:
  - a_oe=0 during a read of 0xAA → a_dout=0x00 while a_valid=1.
  - Raising a_oe afterwards shows 0xAA.
  - A request with a_we=1 and a_oe=1 gives no a_valid.
- Reset mid-operation:
  - rst asserted with a read in flight at latency 2 → no a_valid.
  - rst asserted during the clear sweep at counter 9 → the sweep restarts and busy lasts the full depth.
